lfsr_gen: RTL and testbench



---
 rtl/lfsr_gen.sv | 75 +++++++
 tb/tb_lfsr_gen.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/lfsr_gen.sv
// rtl/lfsr_gen.sv - parametrised Fibonacci LFSR with seed load, lockup recovery and period measurement
module lfsr_gen #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'h9,
  parameter logic [WIDTH-1:0] SEED  = 4'h1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             lockup
);

  logic [WIDTH-1:0] ref_val;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] nxt;
  logic             fb;

  assign fb         = ^(q & TAPS);
  assign nxt        = {q[WIDTH-2:0], fb};
  assign cnt_inc    = (cnt == '1) ? cnt : cnt + WIDTH'(1);
  assign serial_out = q[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q            <= SEED;
      ref_val      <= SEED;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      wrap         <= 1'b0;
      lockup       <= 1'b0;
    end else begin
      wrap   <= 1'b0;
      lockup <= 1'b0;
      if (load) begin
        cnt <= '0;
        if (seed_in != '0) begin
          q       <= seed_in;
          ref_val <= seed_in;
        end else begin
          q       <= SEED;
          ref_val <= SEED;
          lockup  <= 1'b1;
        end
      end else if (en) begin
        // zero is a fixed point of the XOR feedback, so restart from SEED
        if (q == '0) begin
          q       <= SEED;
          ref_val <= SEED;
          cnt     <= '0;
          lockup  <= 1'b1;
        end else begin
          q <= nxt;
          if (nxt == ref_val) begin
            wrap         <= 1'b1;
            period       <= cnt_inc;
            period_valid <= 1'b1;
            cnt          <= '0;
          end else begin
            cnt <= cnt_inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// tb/tb_lfsr_gen.sv - directed self-checking bench for lfsr_gen
module tb_lfsr_gen;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] seed_in;
  logic [3:0] q;
  logic       serial_out;
  logic       wrap;
  logic [3:0] period;
  logic       period_valid;
  logic       lockup;

  int total;
  int bad;

  logic [3:0] seq [15] = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB,
                           4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};

  lfsr_gen #(.WIDTH(4), .TAPS(4'h9), .SEED(4'h1)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .load         (load),
    .seed_in      (seed_in),
    .q            (q),
    .serial_out   (serial_out),
    .wrap         (wrap),
    .period       (period),
    .period_valid (period_valid),
    .lockup       (lockup)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    en      = 1'b0;
    load    = 1'b0;
    seed_in = 4'h0;
    #1;
    chk("rst_q_async", q, 4'h1);
    repeat (3) step();
    rst = 1'b0;

    // idle after reset
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_q", q, 4'h1);
      chk("idle_wrap", wrap, 1'b0);
      chk("idle_lockup", lockup, 1'b0);
      chk("idle_pv", period_valid, 1'b0);
    end

    // full period from SEED
    en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("run_q", q, seq[i]);
      chk("run_serial", serial_out, seq[i][3]);
      chk("run_wrap", wrap, (i == 14));
    end
    chk("run_period", period, 4'd15);
    chk("run_pv", period_valid, 1'b1);

    // runtime seed load, then full period from A
    en = 1'b0; load = 1'b1; seed_in = 4'hA;
    step();
    chk("loadA_q", q, 4'hA);
    chk("loadA_wrap", wrap, 1'b0);
    load = 1'b0; en = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      step();
      chk("seedA_q", q, seq[(5 + k) % 15]);
      chk("seedA_wrap", wrap, (k == 15));
      chk("seedA_period", period, 4'd15);
    end

    // advance a little so cnt is non-zero, then reject a zero seed
    repeat (3) step();
    en = 1'b0; load = 1'b1; seed_in = 4'h0;
    step();
    chk("zero_q", q, 4'h1);
    chk("zero_lockup", lockup, 1'b1);
    chk("zero_period", period, 4'd15);
    load = 1'b0;
    step();
    chk("zero_lockup_clr", lockup, 1'b0);
    chk("zero_q_hold", q, 4'h1);
    en = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("zero_run_wrap", wrap, (i == 14));
    end
    chk("zero_run_period", period, 4'd15);

    // load has priority over en
    load = 1'b1; en = 1'b1; seed_in = 4'h6;
    step();
    chk("prio_q", q, 4'h6);
    load = 1'b0;
    step();
    chk("prio_next_q", q, 4'hC);

    // async reset mid-sequence
    en = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_q", q, 4'hD);
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_q", q, 4'h1);
    chk("arst_pv", period_valid, 1'b0);
    chk("arst_period", period, 4'h0);
    step();
    rst = 1'b0; en = 1'b1;
    step();
    chk("post_rst_q", q, 4'h3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
